// File: rtl/cv32e40x_rf_scoreboard.sv
// -----------------------------------------------------------------------------
// cv32e40x_rf_scoreboard
//
// Register-file scoreboard for writes that complete after commit (out-of-order
// coprocessor results, deferred load data). Every committed instruction with a
// deferred write is "issued" into a per-register pending counter. Every result
// writeback retires one pending write. From these counters the block derives
// RAW/WAW stalls for the instruction in ID and backpressure towards commit.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   issue_valid_i/      committed deferred write and its destination; the
//   issue_waddr_i       source holds it stable until issue_ready_o
//   issue_ready_o       room in both the global and the per-register budget
//   result_valid_i/     one retiring write per result port per cycle
//   result_waddr_i
//   rf_re_id_i/         ID read enables and addresses (RAW check)
//   rf_raddr_id_i
//   rf_we_id_i/         ID write enable and address (WAW check)
//   rf_waddr_id_i
//   id_valid_i          ID holds a valid instruction
//   raw_stall_o         an enabled ID read hits a pending register
//   waw_stall_o         the ID write targets a register already at MAX_PER_REG
//   pending_o           bit r set while register r has writes outstanding
//   outstanding_cnt_o   total outstanding deferred writes
//   empty_o             no writes outstanding
//   underflow_err_o     one-cycle pulse: a result hit a register with nothing
//                       pending
// -----------------------------------------------------------------------------

// Checker for the scoreboard. The per-register and global counters are kept
// out of saturation by issue_ready_o; a violation here means that gating is
// broken.
module cv32e40x_rf_scoreboard_chk (
    input logic clk,
    input logic rst,
    input logic sat_viol_i
);

    a_no_saturation: assert property (@(posedge clk) disable iff (rst) !sat_viol_i);

endmodule

module cv32e40x_rf_scoreboard #(
    parameter int unsigned  REGFILE_NUM_READ_PORTS = 2,
    parameter int unsigned  NUM_RESULT_PORTS       = 1,
    parameter int unsigned  MAX_OUTSTANDING        = 4,
    parameter int unsigned  MAX_PER_REG            = 2,
    parameter bit           RESULT_BYPASS          = 1'b0,
    localparam int unsigned GCNT_W                 = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,

    input  logic                                   issue_valid_i,
    input  logic [4:0]                             issue_waddr_i,
    output logic                                   issue_ready_o,

    input  logic [NUM_RESULT_PORTS-1:0]            result_valid_i,
    input  logic [NUM_RESULT_PORTS-1:0][4:0]       result_waddr_i,

    input  logic [REGFILE_NUM_READ_PORTS-1:0]      rf_re_id_i,
    input  logic [REGFILE_NUM_READ_PORTS-1:0][4:0] rf_raddr_id_i,
    input  logic                                   rf_we_id_i,
    input  logic [4:0]                             rf_waddr_id_i,
    input  logic                                   id_valid_i,

    output logic                                   raw_stall_o,
    output logic                                   waw_stall_o,
    output logic [31:0]                            pending_o,
    output logic [GCNT_W-1:0]                      outstanding_cnt_o,
    output logic                                   empty_o,
    output logic                                   underflow_err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_PER_REG + 1);
    // Common arithmetic width, wide enough for counter + issue + all result hits
    // without wrapping, so comparisons never need to reason about overflow.
    localparam int unsigned AW    = 16;

    localparam logic [AW-1:0] ONE_A     = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] MAX_OUT_A = AW'(MAX_OUTSTANDING);
    localparam logic [AW-1:0] MAX_REG_A = AW'(MAX_PER_REG);

    // Counter state; entry 0 exists only to keep indexing uniform and is
    // held at zero so x0 never reports pending.
    logic [CNT_W-1:0]  cnt_q [32];
    logic [CNT_W-1:0]  cnt_d [32];
    logic [GCNT_W-1:0] gcnt_q;
    logic [GCNT_W-1:0] gcnt_d;
    logic [31:0]       pending_q;
    logic [31:0]       pending_d;
    logic              empty_q;
    logic              uflow_q;
    logic              uflow_d;

    logic [AW-1:0]     hits_s [32];
    logic [AW-1:0]     gcnt_a_s;
    logic [AW-1:0]     issue_cnt_a_s;
    logic [AW-1:0]     waw_cnt_a_s;
    logic              issue_ready_s;
    logic              issue_acc_s;
    logic [31:0]       pend_eff_s;
    logic              raw_hit_s;
    logic              sat_viol_s;

    // Number of result ports retiring a write to each register this cycle.
    always_comb begin
        hits_s[0] = '0;
        for (int r = 1; r < 32; r++) begin
            hits_s[r] = '0;
            for (int p = 0; p < int'(NUM_RESULT_PORTS); p++) begin
                if (result_valid_i[p] && (result_waddr_i[p] == 5'(r))) begin
                    hits_s[r] = hits_s[r] + ONE_A;
                end else begin
                    hits_s[r] = hits_s[r];
                end
            end
        end
    end

    // Issue acceptance looks at registered state only; a result retiring in
    // the same cycle frees room one cycle later, never combinationally.
    assign gcnt_a_s      = AW'(gcnt_q);
    assign issue_cnt_a_s = AW'(cnt_q[issue_waddr_i]);
    assign issue_ready_s = (gcnt_a_s < MAX_OUT_A) &&
                           ((issue_waddr_i == 5'd0) || (issue_cnt_a_s < MAX_REG_A));
    assign issue_acc_s   = issue_valid_i && issue_ready_s;

    // Next-state counters: cnt' = cnt + issue_hit - result_hits, clamped at 0.
    // The global count moves by the same net amount, so retirements that hit
    // an empty register are not subtracted from it.
    always_comb begin
        logic [AW-1:0] avail_v;
        logic [AW-1:0] gacc_v;
        gacc_v     = gcnt_a_s;
        uflow_d    = 1'b0;
        sat_viol_s = 1'b0;
        cnt_d[0]   = '0;
        for (int r = 1; r < 32; r++) begin
            avail_v = AW'(cnt_q[r]);
            if (issue_acc_s && (issue_waddr_i == 5'(r))) begin
                avail_v = avail_v + ONE_A;
                gacc_v  = gacc_v + ONE_A;
            end else begin
                avail_v = avail_v;
            end
            if (hits_s[r] > avail_v) begin
                cnt_d[r] = '0;
                uflow_d  = 1'b1;
                gacc_v   = gacc_v - avail_v;
            end else begin
                cnt_d[r] = CNT_W'(avail_v - hits_s[r]);
                gacc_v   = gacc_v - hits_s[r];
                if ((avail_v - hits_s[r]) > MAX_REG_A) begin
                    sat_viol_s = 1'b1;
                end else begin
                    sat_viol_s = sat_viol_s;
                end
            end
        end
        gcnt_d = GCNT_W'(gacc_v);
        if (gacc_v > MAX_OUT_A) begin
            sat_viol_s = 1'b1;
        end else begin
            sat_viol_s = sat_viol_s;
        end
    end

    // Pending bitmap for the next cycle, derived from the next counters.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pending_d[r] = (cnt_d[r] != '0);
        end
    end

    // Effective pending view for RAW: with bypass, a register whose every
    // outstanding write retires this cycle no longer stalls the reader.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            if (RESULT_BYPASS) begin
                pend_eff_s[r] = (AW'(cnt_q[r]) > hits_s[r]);
            end else begin
                pend_eff_s[r] = pending_q[r];
            end
        end
    end

    // RAW check across all ID read ports; x0 reads never stall.
    always_comb begin
        raw_hit_s = 1'b0;
        for (int i = 0; i < int'(REGFILE_NUM_READ_PORTS); i++) begin
            if (rf_re_id_i[i] && (rf_raddr_id_i[i] != 5'd0) && pend_eff_s[rf_raddr_id_i[i]]) begin
                raw_hit_s = 1'b1;
            end else begin
                raw_hit_s = raw_hit_s;
            end
        end
    end

    assign waw_cnt_a_s = AW'(cnt_q[rf_waddr_id_i]);
    assign raw_stall_o = id_valid_i && raw_hit_s;
    assign waw_stall_o = id_valid_i && rf_we_id_i && (rf_waddr_id_i != 5'd0) &&
                         (waw_cnt_a_s >= MAX_REG_A);

    // Scoreboard state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            gcnt_q    <= '0;
            pending_q <= 32'h0000_0000;
            empty_q   <= 1'b1;
            uflow_q   <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            gcnt_q    <= gcnt_d;
            pending_q <= pending_d;
            empty_q   <= (gcnt_d == '0);
            uflow_q   <= uflow_d;
        end
    end

    assign issue_ready_o     = issue_ready_s;
    assign pending_o         = pending_q;
    assign outstanding_cnt_o = gcnt_q;
    assign empty_o           = empty_q;
    assign underflow_err_o   = uflow_q;

    cv32e40x_rf_scoreboard_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .sat_viol_i (sat_viol_s)
    );

endmodule

// File: tb/tb_cv32e40x_rf_scoreboard.sv
module tb_cv32e40x_rf_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            issue_valid;
    logic [4:0]      issue_waddr;
    logic [1:0]      result_valid;
    logic [1:0][4:0] result_waddr;
    logic [1:0]      rf_re;
    logic [1:0][4:0] rf_raddr;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic            id_valid;

    logic        ready0, raw0, waw0, empty0, uf0;
    logic [31:0] pend0;
    logic [2:0]  ocnt0;
    logic        ready1, raw1, waw1, empty1, uf1;
    logic [31:0] pend1;
    logic [2:0]  ocnt1;

    cv32e40x_rf_scoreboard #(
        .REGFILE_NUM_READ_PORTS (2), .NUM_RESULT_PORTS (2),
        .MAX_OUTSTANDING (4), .MAX_PER_REG (2), .RESULT_BYPASS (1'b0)
    ) dut0 (
        .clk (clk), .rst (rst),
        .issue_valid_i (issue_valid), .issue_waddr_i (issue_waddr), .issue_ready_o (ready0),
        .result_valid_i (result_valid), .result_waddr_i (result_waddr),
        .rf_re_id_i (rf_re), .rf_raddr_id_i (rf_raddr),
        .rf_we_id_i (rf_we), .rf_waddr_id_i (rf_waddr), .id_valid_i (id_valid),
        .raw_stall_o (raw0), .waw_stall_o (waw0), .pending_o (pend0),
        .outstanding_cnt_o (ocnt0), .empty_o (empty0), .underflow_err_o (uf0)
    );

    cv32e40x_rf_scoreboard #(
        .REGFILE_NUM_READ_PORTS (2), .NUM_RESULT_PORTS (2),
        .MAX_OUTSTANDING (4), .MAX_PER_REG (2), .RESULT_BYPASS (1'b1)
    ) dut1 (
        .clk (clk), .rst (rst),
        .issue_valid_i (issue_valid), .issue_waddr_i (issue_waddr), .issue_ready_o (ready1),
        .result_valid_i (result_valid), .result_waddr_i (result_waddr),
        .rf_re_id_i (rf_re), .rf_raddr_id_i (rf_raddr),
        .rf_we_id_i (rf_we), .rf_waddr_id_i (rf_waddr), .id_valid_i (id_valid),
        .raw_stall_o (raw1), .waw_stall_o (waw1), .pending_o (pend1),
        .outstanding_cnt_o (ocnt1), .empty_o (empty1), .underflow_err_o (uf1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pending write count per register, plus underflow flag.
    int mc [32];
    bit muf;

    function automatic int hits(input int r);
        int n = 0;
        for (int p = 0; p < 2; p++)
            if (result_valid[p] && int'(result_waddr[p]) == r && r != 0) n++;
        return n;
    endfunction

    function automatic int gsum();
        int g = 0;
        for (int r = 1; r < 32; r++) g += mc[r];
        return g;
    endfunction

    function automatic bit mready();
        return (gsum() < 4) && (issue_waddr == 5'd0 || mc[issue_waddr] < 2);
    endfunction

    task automatic check_dut(input string tag, input logic rdy, input logic raw, input logic waw,
                             input logic [31:0] pend, input logic [2:0] ocnt, input logic emp,
                             input logic uf, input bit e_rdy, input bit e_raw, input bit e_waw,
                             input logic [31:0] e_pend, input int e_g, input bit e_uf);
        chk({tag, " ready"},    32'(rdy),  32'(e_rdy));
        chk({tag, " raw"},      32'(raw),  32'(e_raw));
        chk({tag, " waw"},      32'(waw),  32'(e_waw));
        chk({tag, " pending"},  pend,      e_pend);
        chk({tag, " count"},    32'(ocnt), 32'(e_g));
        chk({tag, " empty"},    32'(emp),  32'(e_g == 0));
        chk({tag, " underflow"},32'(uf),   32'(e_uf));
    endtask

    task automatic model_check(output bit rdy_o);
        int g;
        bit rdy, rawa, rawb, waw;
        logic [31:0] pend;
        g = gsum();
        pend = '0;
        for (int r = 1; r < 32; r++) if (mc[r] != 0) pend[r] = 1'b1;
        rdy = mready();
        rawa = 1'b0;
        rawb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (id_valid && rf_re[i] && rf_raddr[i] != 5'd0) begin
                if (mc[rf_raddr[i]] > 0) rawa = 1'b1;
                if (mc[rf_raddr[i]] > hits(int'(rf_raddr[i]))) rawb = 1'b1;
            end
        end
        waw = id_valid && rf_we && rf_waddr != 5'd0 && mc[rf_waddr] >= 2;
        check_dut("d0", ready0, raw0, waw0, pend0, ocnt0, empty0, uf0, rdy, rawa, waw, pend, g, muf);
        check_dut("d1", ready1, raw1, waw1, pend1, ocnt1, empty1, uf1, rdy, rawb, waw, pend, g, muf);
        rdy_o = rdy;
    endtask

    task automatic model_update();
        bit acc, uf;
        int n;
        if (rst) begin
            for (int r = 0; r < 32; r++) mc[r] = 0;
            muf = 1'b0;
        end else begin
            acc = issue_valid && mready();
            uf  = 1'b0;
            for (int r = 1; r < 32; r++) begin
                n = mc[r] + ((acc && int'(issue_waddr) == r) ? 1 : 0) - hits(r);
                if (n < 0) begin
                    n  = 0;
                    uf = 1'b1;
                end
                mc[r] = n;
            end
            muf = uf;
        end
    endtask

    typedef struct {
        bit       rst;
        bit       iv;
        bit [4:0] iwa;
        bit [1:0] rv;
        bit [4:0] rwa0;
        bit [4:0] rwa1;
        bit       idv;
        bit [1:0] re;
        bit [4:0] ra0;
        bit [4:0] ra1;
        bit       we;
        bit [4:0] wa;
        bit       chk;
        bit       e_ready;
        bit       e_raw;
        bit       e_rawb;
        bit       e_waw;
        int       e_cnt;
        bit       e_uf;
        longint   e_pend;   // -1: not checked
    } vec_t;

    function automatic vec_t mk(input int rs, iv, iwa, rv, rwa0, rwa1, idv, re, ra0, ra1, we, wa,
                                input int e_ready, e_raw, e_rawb, e_waw, e_cnt, e_uf);
        vec_t v;
        v.rst = 1'(rs);  v.iv = 1'(iv);   v.iwa = 5'(iwa);
        v.rv = 2'(rv);   v.rwa0 = 5'(rwa0); v.rwa1 = 5'(rwa1);
        v.idv = 1'(idv); v.re = 2'(re);   v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
        v.we = 1'(we);   v.wa = 5'(wa);
        v.chk = 1'b1;
        v.e_ready = 1'(e_ready); v.e_raw = 1'(e_raw); v.e_rawb = 1'(e_rawb);
        v.e_waw = 1'(e_waw); v.e_cnt = e_cnt; v.e_uf = 1'(e_uf);
        v.e_pend = -1;
        return v;
    endfunction

    // Drive on the falling edge, check 1 time unit later, advance the model on
    // the rising edge.
    task automatic run_vec(input vec_t v, input string name, output bit rdy_o);
        bit rdy;
        rst = v.rst; issue_valid = v.iv; issue_waddr = v.iwa;
        result_valid = v.rv; result_waddr[0] = v.rwa0; result_waddr[1] = v.rwa1;
        id_valid = v.idv; rf_re = v.re; rf_raddr[0] = v.ra0; rf_raddr[1] = v.ra1;
        rf_we = v.we; rf_waddr = v.wa;
        #1;
        model_check(rdy);
        if (v.chk) begin
            chk({name, " ready"},  32'(ready0), 32'(v.e_ready));
            chk({name, " raw"},    32'(raw0),   32'(v.e_raw));
            chk({name, " rawbyp"}, 32'(raw1),   32'(v.e_rawb));
            chk({name, " waw"},    32'(waw0),   32'(v.e_waw));
            chk({name, " count"},  32'(ocnt0),  32'(v.e_cnt));
            chk({name, " uflow"},  32'(uf0),    32'(v.e_uf));
            if (v.e_pend >= 0) chk({name, " pend"}, pend0, 32'(v.e_pend));
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
        rdy_o = rdy;
    endtask

    vec_t tbl [$];
    vec_t v;
    bit   rdy;
    bit   hold;
    logic [4:0] hold_a;

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_waddr = 5'd0;
        result_valid = 2'b00; result_waddr = '0; rf_re = 2'b00; rf_raddr = '0;
        rf_we = 1'b0; rf_waddr = 5'd0; id_valid = 1'b0;
        for (int r = 0; r < 32; r++) mc[r] = 0;
        muf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        //            rs iv iwa rv r0 r1 idv re ra0 ra1 we wa | rdy raw rawb waw cnt uf
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 5, 0, 0,  1, 0, 0, 0, 0, 0)); // T0 reset state
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, 1, 2, 0, 5, 0, 0,  1, 0, 0, 0, 0, 0)); // T1 issue x5
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 5, 0, 0,  1, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 5, 0, 0,  1, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 0, 1, 2, 0, 5, 0, 0,  1, 1, 0, 0, 1, 0)); // T4 result x5
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2, 0, 5, 0, 0,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 0, 0, 1, 0, 0, 0, 1, 7,  1, 0, 0, 0, 0, 0)); // T6 x7 twice
        tbl.push_back(mk(0, 1, 7, 0, 0, 0, 1, 0, 0, 0, 1, 7,  1, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 7, 0, 0, 0, 1, 0, 0, 0, 1, 7,  0, 0, 0, 1, 2, 0)); // T8 x7 full
        tbl.push_back(mk(0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 1, 7,  0, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 3, 7, 7, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2, 0)); // T10 two results x7
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0)); // T12 x9 cnt=1
        tbl.push_back(mk(0, 1, 9, 1, 9, 0, 1, 1, 9, 0, 0, 0,  1, 1, 0, 0, 1, 0)); // T13 issue+result
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0,  1, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 9, 3, 9, 9, 1, 1, 9, 0, 0, 0,  1, 1, 0, 0, 1, 0)); // T15 issue+2 results
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 2, 0,12, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0)); // T17 underflow x12
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 3, 0, 0, 1, 3, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0)); // T20 x0 traffic
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("T%0d", i), rdy);

        // Global limit: x1..x4 fill the budget, x6 is held until x2 retires.
        run_vec(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0), "A1", rdy);
        run_vec(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1, 0), "A2", rdy);
        run_vec(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2, 0), "A3", rdy);
        run_vec(mk(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3, 0), "A4", rdy);
        run_vec(mk(0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 0), "A5", rdy);
        run_vec(mk(0, 1, 6, 1, 2, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 0), "A6", rdy);
        run_vec(mk(0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3, 0), "A7", rdy);
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 0);
        v.e_pend = 64'h5A;
        run_vec(v, "A8", rdy);

        // Reset with three writes outstanding, then a stale result.
        run_vec(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4, 0), "B1", rdy);
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 3, 0);
        v.e_pend = 64'h58;
        run_vec(v, "B2", rdy);
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        v.e_pend = 64'h0;
        run_vec(v, "B3", rdy);
        run_vec(mk(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0), "B4", rdy);
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 1), "B5", rdy);
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0), "B6", rdy);

        // Random traffic on a small register window, checked against the model.
        hold   = 1'b0;
        hold_a = 5'd0;
        for (int n = 0; n < 3000; n++) begin
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
            v.chk  = 1'b0;
            v.rst  = ($urandom_range(0, 249) == 0);
            if (hold) begin
                v.iv  = 1'b1;
                v.iwa = hold_a;
            end else begin
                v.iv  = 1'($urandom_range(0, 1));
                v.iwa = 5'($urandom_range(0, 7));
            end
            v.rv[0] = ($urandom_range(0, 2) == 0);
            v.rv[1] = ($urandom_range(0, 3) == 0);
            v.rwa0  = 5'($urandom_range(0, 7));
            v.rwa1  = 5'($urandom_range(0, 7));
            v.idv   = 1'($urandom_range(0, 1));
            v.re    = 2'($urandom_range(0, 3));
            v.ra0   = 5'($urandom_range(0, 7));
            v.ra1   = 5'($urandom_range(0, 7));
            v.we    = 1'($urandom_range(0, 1));
            v.wa    = 5'($urandom_range(0, 7));
            run_vec(v, "rnd", rdy);
            hold   = v.iv && !rdy && !v.rst;
            hold_a = v.iwa;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40x_rf_scoreboard.md
Name: cv32e40x_rf_scoreboard

Overview:
- Parametrised successor to the ID-stage hazard/bypass control: a register-file scoreboard for register writes that complete after commit, such as XIF results returned out of order or deferred load data.
- Receives commit-time "issue" events and asynchronous result writebacks on one or more result ports.
- Keeps a per-register outstanding-write counter and a global outstanding counter.
- Drives RAW and WAW stalls for the instruction in ID, and backpressures commit.

Parameters:
REGFILE_NUM_READ_PORTS, 2, number of ID read ports checked for RAW
NUM_RESULT_PORTS, 1, number of writeback result ports, each of which may retire one write per cycle
MAX_OUTSTANDING, 4, global limit of pending deferred writes (>=1)
MAX_PER_REG, 2, per-register pending-write limit (1..MAX_OUTSTANDING)
RESULT_BYPASS, 0, if 1 then same-cycle results that clear a register remove its stall combinationally

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_valid_i  in  1  committed instruction with deferred rf write
issue_waddr_i  in  5  destination register of the issue
issue_ready_o  out  1  scoreboard can accept an issue this cycle
result_valid_i  in  NUM_RESULT_PORTS  result write occurring this cycle
result_waddr_i  in  NUM_RESULT_PORTS x 5  destination of each result
rf_re_id_i  in  REGFILE_NUM_READ_PORTS  ID read enables
rf_raddr_id_i  in  REGFILE_NUM_READ_PORTS x 5  ID read addresses
rf_we_id_i  in  1  ID instruction writes rf
rf_waddr_id_i  in  5  ID write address
id_valid_i  in  1  ID holds a valid instruction (if_id_pipe instr_valid)
raw_stall_o  out  1  ID read hits a pending register
waw_stall_o  out  1  ID write hits a register at MAX_PER_REG
pending_o  out  32  bit r set when counter[r] != 0
outstanding_cnt_o  out  $clog2(MAX_OUTSTANDING+1)  global pending count
empty_o  out  1  outstanding_cnt_o == 0
underflow_err_o  out  1  one-cycle pulse: a result targeted a register with counter 0

Behaviour:
- State: cnt[1..31], each of width $clog2(MAX_PER_REG+1); global counter gcnt. x0 has no counter; pending_o[0] is always 0.
- Reset (rst sampled high on clk edge): all counters 0. Outputs after reset: pending_o=0, outstanding_cnt_o=0, empty_o=1, issue_ready_o=1, underflow_err_o=0. raw_stall_o and waw_stall_o are 0 whenever id_valid_i=0. Reset asserted mid-operation discards all pending state. Results arriving afterwards raise underflow_err_o.
- Issue handshake: an issue is accepted when issue_valid_i && issue_ready_o.
  - issue_ready_o = (gcnt < MAX_OUTSTANDING) && (issue_waddr_i==0 || cnt[issue_waddr_i] < MAX_PER_REG). It uses registered state only and ignores same-cycle results.
  - An accepted issue to x0 is a no-op and does not change gcnt.
  - issue_valid_i while issue_ready_o=0 must be held stable by the source until it is accepted.
- Results: each valid port with waddr!=0 decrements cnt[waddr] by 1.
  - Several ports on the same register in the same cycle decrement once per port.
  - If that total exceeds cnt plus any same-cycle issue to that register, the counter clamps at 0 and underflow_err_o pulses the next cycle. gcnt decrements only by the non-underflowing amount.
  - A result to x0 is ignored.
- Update per register, next cycle: cnt' = cnt + issue_hit - result_hits (clamped at 0). A same-cycle issue and result on one register net to zero. gcnt' is updated by the same net rule.
- Latency: an issue is visible on pending_o and stalls from the next cycle. A result clears pending_o on the next cycle.
- raw_stall_o = id_valid_i && OR over i of (rf_re_id_i[i] && rf_raddr_id_i[i]!=0 && pend_eff[rf_raddr_id_i[i]]).
  - pend_eff = registered pending when RESULT_BYPASS=0.
  - When RESULT_BYPASS=1, pend_eff[r] = (cnt[r] > result hits on r this cycle).
- waw_stall_o = id_valid_i && rf_we_id_i && rf_waddr_id_i!=0 && cnt[rf_waddr_id_i] >= MAX_PER_REG. This uses registered state only.
- Counters never wrap. Saturation is prevented by issue_ready_o, and the design checks this with an assertion.

Test Plan:
- Reset: after rst, pending_o=0, empty_o=1, issue_ready_o=1, and ID reading x5 with no prior issue gives raw_stall_o=0.
- Issue x5 at cycle t, ID reads x5 on port 1 -> raw_stall_o=1 from t+1. Result x5 at t+3 -> raw_stall_o=0 at t+4 (RESULT_BYPASS=0), or already at t+3 (RESULT_BYPASS=1).
- MAX_OUTSTANDING=4: issue x1..x4 -> issue_ready_o=0 and outstanding_cnt_o=4. Issue x6 is held. A result on x2 -> x6 is accepted the next cycle and the count returns to 4.
- MAX_PER_REG=2: issue x7 twice -> issue_ready_o=0 for x7 and waw_stall_o=1 for an ID write to x7. Two results on x7 -> pending_o[7]=0.
- Simultaneous issue x9 and result x9 with cnt[9]=1 -> cnt stays 1 and pending_o[9]=1. With NUM_RESULT_PORTS=2 and both ports on x9 -> cnt=0, no error.
- Result on x12 with cnt 0 -> underflow_err_o=1 for exactly one cycle, counters unchanged. Issue/result to x0 -> no state change. rst mid-stream with 3 pending -> all cleared next cycle.
